// File: rtl/mem_arbiter.sv
// Two-master arbiter sharing one memory port between instruction fetch and data access.
// Data normally wins; a bounded starvation counter guarantees forward progress for fetch.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX  = 4,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_sel,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        mem_ce,
  output logic        mem_we,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err,
  output logic [5:0]  stall
);

  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          if_ack_q, dm_ack_q, bus_err_q;
  logic [31:0]   if_rdata_q, dm_rdata_q;
  logic          mem_we_q;
  logic [3:0]    mem_sel_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;
  logic          load_i, load_d, done, timeout;
  logic          if_req_m, dm_req_m;

  // A requester whose ack is on the bus this cycle is still holding req; ignore it.
  assign if_req_m = if_req & ~if_ack_q;
  assign dm_req_m = dm_req & ~dm_ack_q;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    wait_d   = wait_q;
    load_i   = 1'b0;
    load_d   = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dm_req_m && (starve_q < SW'(STARVE_MAX))) begin
          load_d = 1'b1;
        end else if (if_req_m) begin
          load_i = 1'b1;
        end else if (dm_req_m) begin
          load_d = 1'b1;
        end
        if (load_d) begin
          state_d = StGntD;
          wait_d  = '0;
          // Only a fetch that is genuinely waiting counts toward starvation.
          if (if_req_m && (starve_q < SW'(STARVE_MAX))) starve_d = starve_q + SW'(1);
        end
        if (load_i) begin
          state_d  = StGntI;
          wait_d   = '0;
          starve_d = '0;
        end
      end
      StGntI, StGntD: begin
        if (mem_ready) begin
          done = 1'b1;
        end else if (wait_q == WW'(TIMEOUT_CYC - 1)) begin
          done    = 1'b1;
          timeout = 1'b1;
        end else begin
          wait_d = wait_q + WW'(1);
        end
        if (done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      wait_q      <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      wait_q    <= wait_d;
      if_ack_q  <= done && (state_q == StGntI);
      dm_ack_q  <= done && (state_q == StGntD);
      bus_err_q <= timeout;
      if (done && (state_q == StGntI)) if_rdata_q <= timeout ? 32'h0 : mem_rdata;
      if (done && (state_q == StGntD)) dm_rdata_q <= timeout ? 32'h0 : mem_rdata;
      if (load_i) begin
        mem_we_q    <= 1'b0;
        mem_sel_q   <= 4'b1111;
        mem_addr_q  <= if_addr;
        mem_wdata_q <= 32'h0;
      end else if (load_d) begin
        mem_we_q    <= dm_we;
        mem_sel_q   <= dm_sel;
        mem_addr_q  <= dm_addr;
        mem_wdata_q <= dm_wdata;
      end
    end
  end

  always_comb begin
    stall = 6'b000000;
    if (!rst) begin
      if (dm_req && !dm_ack_q) begin
        stall = 6'b011111;
      end else if (if_req && !if_ack_q) begin
        stall = 6'b000111;
      end
    end
  end

  assign mem_ce    = (state_q != StIdle);
  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table, corner sequences, and random traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int STARVE = 4;
  localparam int TOUT   = 16;

  logic        clk, rst;
  logic        if_req, dm_req, dm_we, mem_ready;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_sel;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, dm_ack, mem_ce, mem_we, bus_err;
  logic [3:0]  mem_sel;
  logic [5:0]  stall;

  mem_arbiter #(.STARVE_MAX(STARVE), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_sel(dm_sel), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the memory, how long it has waited, pending acks.
  int          m_owner;  // 0 none, 1 fetch, 2 data
  int          m_starve, m_wait;
  bit          m_if_ack, m_dm_ack, m_berr;
  logic [31:0] m_if_rdata, m_dm_rdata, m_addr, m_wdata;
  logic        m_we;
  logic [3:0]  m_sel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_starve = 0; m_wait = 0;
    m_if_ack = 0; m_dm_ack = 0; m_berr = 0;
    m_if_rdata = '0; m_dm_rdata = '0; m_addr = '0; m_wdata = '0; m_we = 0; m_sel = '0;
  endtask

  task automatic model_step();
    bit iw, dw, fin, to;
    iw = if_req && !m_if_ack;
    dw = dm_req && !m_dm_ack;
    m_if_ack = 0; m_dm_ack = 0; m_berr = 0;
    if (m_owner != 0) begin
      fin = mem_ready || (m_wait == TOUT - 1);
      to  = !mem_ready && fin;
      if (!fin) m_wait++;
      else begin
        if (m_owner == 1) begin m_if_ack = 1; m_if_rdata = to ? 32'h0 : mem_rdata; end
        else begin m_dm_ack = 1; m_dm_rdata = to ? 32'h0 : mem_rdata; end
        m_berr  = to;
        m_owner = 0;
      end
    end else if (dw && (m_starve < STARVE || !iw)) begin
      m_owner = 2; m_wait = 0;
      m_we = dm_we; m_sel = dm_sel; m_addr = dm_addr; m_wdata = dm_wdata;
      if (iw && m_starve < STARVE) m_starve++;
    end else if (iw) begin
      m_owner = 1; m_wait = 0; m_starve = 0;
      m_we = 0; m_sel = 4'hF; m_addr = if_addr; m_wdata = 0;
    end
  endtask

  task automatic model_check();
    logic [5:0] exp_st;
    exp_st = 6'b0;
    if (!rst) begin
      if (dm_req && !m_dm_ack) exp_st = 6'b011111;
      else if (if_req && !m_if_ack) exp_st = 6'b000111;
    end
    chk("mem_ce", {31'b0, mem_ce}, {31'b0, m_owner != 0});
    chk("if_ack", {31'b0, if_ack}, {31'b0, m_if_ack});
    chk("dm_ack", {31'b0, dm_ack}, {31'b0, m_dm_ack});
    chk("bus_err", {31'b0, bus_err}, {31'b0, m_berr});
    chk("stall", {26'b0, stall}, {26'b0, exp_st});
    if (m_owner != 0) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_we_sel", {27'b0, mem_we, mem_sel}, {27'b0, m_we, m_sel});
    end
    if (m_if_ack) chk("if_rdata", if_rdata, m_if_rdata);
    if (m_dm_ack) chk("dm_rdata", dm_rdata, m_dm_rdata);
  endtask

  // Inputs are set just after a falling edge; look() samples, adv() crosses the rising edge.
  task automatic look();
    #1;
    model_check();
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 0; dm_req = 0; dm_we = 0; dm_sel = 4'hF; mem_ready = 0;
    if_addr = 32'h100; dm_addr = 32'h40; dm_wdata = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    #1;
    chk("rst_ce", {31'b0, mem_ce}, 32'h0);
    chk("rst_outs", {if_ack, dm_ack, bus_err, mem_we, mem_sel, stall}, '0);
    chk("rst_rdata", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'h0);
    adv();
    rst = 0;
  endtask

  typedef struct {
    logic        ifr, dmr, rdy;
    logic [31:0] rd;
    logic        ce, ia, da;
    logic [5:0]  st;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int dcnt, k, acks;
    bit got;
    rst = 1;
    idle_inputs();
    if_req = 1; dm_req = 1;  // stall must still read 0 during reset
    @(negedge clk);
    do_reset();
    idle_inputs();

    // Fetch-only transfer, then simultaneous requests.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 6'b000111, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h34011100, 1'b1, 1'b0, 1'b0, 6'b000111, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 6'b000000, 32'h34011100};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 6'b000000, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 6'b011111, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 32'hAAAA5555, 1'b1, 1'b0, 1'b0, 6'b011111, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 6'b000111, 32'hAAAA5555};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0, 6'b000111, 32'h0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 6'b000000, 32'h12345678};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 6'b000000, 32'h0};
    for (int i = 0; i < 10; i++) begin
      if_req = tbl[i].ifr; dm_req = tbl[i].dmr; mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rd;
      look();
      chk("tbl_ce", {31'b0, mem_ce}, {31'b0, tbl[i].ce});
      chk("tbl_acks", {30'b0, if_ack, dm_ack}, {30'b0, tbl[i].ia, tbl[i].da});
      chk("tbl_stall", {26'b0, stall}, {26'b0, tbl[i].st});
      if (tbl[i].ia) chk("tbl_if_rdata", if_rdata, tbl[i].exp_rd);
      if (tbl[i].da) chk("tbl_dm_rdata", dm_rdata, tbl[i].exp_rd);
      adv();
    end

    // Data write held for three grant cycles while the requester's bus changes underneath.
    dm_req = 1; dm_we = 1; dm_sel = 4'b0011; dm_addr = 32'h20; dm_wdata = 32'hDEADBEEF;
    acks = 0;
    look(); adv();
    for (k = 1; k <= 8; k++) begin
      mem_ready = (k == 3);
      if (k >= 2) begin dm_addr = 32'hBAD0_0000 + k; dm_wdata = 32'h0; dm_sel = 4'hC; end
      if (k >= 5) dm_req = 0;
      look();
      if (k <= 3) begin
        chk("wr_ce", {31'b0, mem_ce}, 32'h1);
        chk("wr_addr", mem_addr, 32'h20);
        chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_we_sel", {27'b0, mem_we, mem_sel}, {27'b0, 1'b1, 4'b0011});
      end
      if (dm_ack) acks++;
      adv();
    end
    chk("wr_ack_count", acks, 1);
    idle_inputs();

    // Timeout: memory never answers.
    if_req = 1; mem_rdata = 32'hFFFF_FFFF;
    look(); adv();
    for (k = 1; k <= 16; k++) begin
      look();
      chk("to_ce", {31'b0, mem_ce}, 32'h1);
      adv();
    end
    look();
    chk("to_ack", {30'b0, if_ack, bus_err}, 32'h3);
    chk("to_rdata", if_rdata, 32'h0);
    chk("to_idle", {31'b0, mem_ce}, 32'h0);
    if_req = 0;
    adv();
    look();
    chk("to_berr_pulse", {31'b0, bus_err}, 32'h0);
    adv();

    // Reset in the middle of a data grant.
    dm_req = 1; dm_addr = 32'h80;
    look(); adv();
    look();
    chk("rg_ce", {31'b0, mem_ce}, 32'h1);
    rst = 1;
    model_reset();
    #1;
    chk("rg_ce_drop", {31'b0, mem_ce}, 32'h0);
    adv();
    rst = 0; dm_req = 0; mem_ready = 1;
    for (k = 0; k < 4; k++) begin
      look();
      chk("rg_no_ack", {31'b0, dm_ack}, 32'h0);
      adv();
    end
    idle_inputs();

    // Starvation: fetch drops only in data-ack cycles, so data keeps winning until the cap.
    do_reset();
    idle_inputs();
    dcnt = 0; got = 0;
    for (k = 0; k < 60 && !got; k++) begin
      dm_req = 1; if_req = !m_dm_ack; mem_ready = 1; mem_rdata = k;
      look();
      if (dm_ack) dcnt++;
      if (if_ack) got = 1;
      adv();
    end
    chk("starve_fetch_seen", {31'b0, got}, 32'h1);
    chk("starve_data_grants", dcnt, STARVE);
    idle_inputs();
    look(); adv();

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      if (m_if_ack || !if_req) if_req = ($urandom % 3) == 0;
      else if (($urandom % 20) == 0) if_req = 0;
      if (m_dm_ack || !dm_req) dm_req = ($urandom % 3) == 0;
      else if (($urandom % 20) == 0) dm_req = 0;
      dm_we = $urandom; dm_sel = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
      if_addr = $urandom; mem_rdata = $urandom;
      mem_ready = ((n / 200) % 3 == 2) ? (($urandom % 24) == 0) : (($urandom % 3) == 0);
      if (($urandom % 600) == 0) begin
        do_reset();
      end else begin
        look(); adv();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: maximum consecutive data grants while a fetch request waits.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 16: number of grant cycles without mem_ready before a bus error is raised.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port: clk  in  1  system clock, rising edge.
REQ-005 Port: rst  in  1  asynchronous active-high reset.
REQ-006 Port: if_req  in  1  instruction-fetch request, held until if_ack.
REQ-007 Port: if_addr  in  32  fetch address.
REQ-008 Port: if_rdata  out  32  fetched instruction, valid while if_ack=1.
REQ-009 Port: if_ack  out  1  one-cycle fetch completion pulse.
REQ-010 Port: dm_req  in  1  data-access request, held until dm_ack.
REQ-011 Port: dm_we  in  1  data write enable.
REQ-012 Port: dm_sel  in  4  byte lane select.
REQ-013 Port: dm_addr  in  32  data address.
REQ-014 Port: dm_wdata  in  32  data write value.
REQ-015 Port: dm_rdata  out  32  data read value, valid while dm_ack=1.
REQ-016 Port: dm_ack  out  1  one-cycle data completion pulse.
REQ-017 Port: mem_ce / mem_we  out  1 each  shared memory chip enable and write enable.
REQ-018 Port: mem_sel  out  4; mem_addr  out  32; mem_wdata  out  32  shared memory lanes, address and write data.
REQ-019 Port: mem_rdata  in  32; mem_ready  in  1  memory read data and completion strobe.
REQ-020 Port: bus_err  out  1  one-cycle pulse with the ack of a timed-out access.
REQ-021 Port: stall  out  6  pipeline stall vector; bit0=PC, bit1=IF, bit2=ID, bit3=EX, bit4=MEM, bit5=WB.

Function
REQ-022 SHALL implement FSM states IDLE, GNT_I and GNT_D.
REQ-023 Arbitration in IDLE, with requests after masking (REQ-028):
- dm_req and starve_cnt<STARVE_MAX -> GNT_D.
- else if_req -> GNT_I.
- else dm_req -> GNT_D.
- else stay in IDLE.
REQ-024 starve_cnt SHALL increment, saturating at STARVE_MAX, on each GNT_D entry while if_req=1; it SHALL clear on GNT_I entry.
REQ-025 On grant entry SHALL register the winner's address, we, sel and wdata onto mem_*; fetch drives we=0, sel=4'b1111, wdata=0.
REQ-026 mem_ce SHALL be 1 exactly while in GNT_I/GNT_D; mem_* outputs SHALL stay stable until completion.
REQ-027 Completion on mem_ready=1 in a grant state:
- Register mem_rdata to the owner's rdata.
- Pulse the owner's ack next cycle.
- Return to IDLE.
- Minimum latency: request in IDLE at cycle 0 -> ack at cycle 2.
REQ-028 In the cycle an ack is high, that requester's req SHALL be masked from arbitration; the other requester may be granted that cycle.
REQ-029 wait_cnt SHALL clear on grant entry and count grant cycles. At wait_cnt=TIMEOUT_CYC-1 with mem_ready=0, it SHALL complete as REQ-027 with rdata=0 and bus_err=1.
REQ-030 Deassertion of req during a grant SHALL NOT abort the access; the ack SHALL still be issued.
REQ-031 mem_ready outside grant states SHALL be ignored.
REQ-032 if_ack and dm_ack SHALL never be high together.
REQ-033 stall (combinational):
- 6'b011111 when dm_req=1 and dm_ack=0.
- else 6'b000111 when if_req=1 and if_ack=0.
- else 6'b000000.

Reset
REQ-034 rst=1 SHALL immediately force:
- State IDLE, starve_cnt=0, wait_cnt=0.
- All outputs 0, including mem_ce, acks, bus_err, rdata and stall.
REQ-035 Reset mid-transaction SHALL discard the access with no ack after release.
REQ-036 After rst falls, arbitration SHALL resume at the first rising edge.

Verification
REQ-037 Fetch only:
- Stimulus: if_req=1, if_addr=0x100; mem_ready=1 in the first grant cycle; mem_rdata=0x34011100.
- Response: mem_ce=1 at cycle 1; if_ack=1 and if_rdata=0x34011100 at cycle 2; stall=000111 for cycles 0-1.
REQ-038 Simultaneous requests:
- Stimulus: if_req and dm_req both high at cycle 0.
- Response: data granted first with stall=011111; fetch granted in the dm_ack cycle.
REQ-039 Starvation:
- Stimulus: dm_req held continuously with if_req=1.
- Response: exactly 4 data grants, then GNT_I, then starve_cnt=0.
REQ-040 Data write:
- Stimulus: dm_we=1, dm_sel=4'b0011, dm_addr=0x20, dm_wdata=0xDEADBEEF, mem_ready after 3 cycles.
- Response: mem_* stable for those 3 cycles; dm_ack pulses once.
REQ-041 Timeout:
- Stimulus: mem_ready held 0.
- Response: ack with bus_err=1 and rdata=0 on the 16th grant cycle's following edge; FSM back in IDLE.
REQ-042 Reset mid-grant:
- Stimulus: rst pulsed during GNT_D.
- Response: mem_ce=0 immediately; no dm_ack after release.
